keyboard: RTL
=============

# keyboard

PS/2 keyboard front end for the TS2068 core. It receives scan-code set 2 frames from a host keyboard and maintains a 40-key Spectrum-style key matrix. It answers the CPU's port-FE keyboard reads by driving `col` from the high address byte presented on `row`. It also raises NMI and reset-request levels from function keys.

## Interface
Parameters:
- `TOUT`, default 56000: idle clock count that aborts a partial PS/2 frame (≈2 ms at 28 MHz).

Ports:
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2Ck`  in  1  PS/2 clock pin, asynchronous.
- `ps2Dt`  in  1  PS/2 data pin, asynchronous.
- `row`  in  8  CPU A[15:8]; a 0 bit selects that half-row.
- `col`  out  5  active-low key columns for port-FE bits 4:0.
- `nmi`  out  1  high while F5 is held.
- `boot`  out  1  high while F11 is held.

## Operation
**Receiver**
- `ps2Ck` and `ps2Dt` each pass through a 2-flop synchroniser.
- A falling edge of the synchronised clock (previous 1, current 0) samples data into an 11-bit shift register and increments the bit counter (0–10).
- On the 11th bit the frame is checked: start = 0, stop = 1, and odd parity over data+parity. Valid frames emit the data byte with a one-cycle strobe. Invalid frames are discarded silently. In both cases the bit counter returns to 0.
- Idle counter: it clears on every falling edge. If the bit counter ≠ 0 and the idle counter reaches `TOUT`, the bit counter returns to 0 and the partial frame is dropped.

**Decoder** (consumes byte strobes)
- 0xF0 sets `brk`; 0xE0 sets `ext`. Both are sticky until the next non-prefix byte.
- Any other byte is a key code with press = !`brk` and extended = `ext`. It updates its mapped sources, then clears `brk` and `ext`.
- 0xE1, 0xAA, 0xFA, 0xEE, 0xFE, and unmapped codes change nothing except clearing `brk`/`ext`.

**Matrix layout.** The bit-0-first ordering per `row` bit:
- r0 CS Z X C V
- r1 A S D F G
- r2 Q W E R T
- r3 1 2 3 4 5
- r4 0 9 8 7 6
- r5 P O I U Y
- r6 ENTER L K J H
- r7 SPACE SS M N B

**Host key mapping**
- Letters, digits, Space and Enter map directly.
- Left Shift → CS.
- Right Shift and Left Ctrl → SS.
- Backspace → CS+0.
- Extended arrows map as: left → CS+5, down → CS+6, up → CS+7, right → CS+8.
- F5 → `nmi`; F11 → `boot`.

**Source flags.** Each matrix key is the OR of the independent flags of every host key mapped to it. Releasing one host key never clears a matrix key still held by another host key. For example, with Shift held, releasing Backspace leaves CS pressed.

**Column output.** `col[i]` = NOT (OR over r with `row[r]`==0 of key[r][i]). Multiple selected rows combine as wired-AND. `row`=0xFF yields 5'b11111.

## Timing
- Reset (async assert) clears all of the following:
  - key flags
  - `brk`, `ext`
  - bit counter, idle counter
  - synchroniser flops, which are set to 1
- Reset outputs: `col`=5'b11111, `nmi`=0, `boot`=0.
- Release of `reset` is synchronous to `clock`.
- `col` is combinational from `row` and the registered matrix: zero-cycle latency, as the CPU samples it within the same I/O cycle.
- A key-state change is visible on `col`/`nmi`/`boot` no later than 4 `clock` cycles after the 11th PS/2 falling edge reaches the pin.
- A new frame starting while a byte is being decoded is unaffected, because decoding takes one cycle.
- Reset mid-frame discards the frame and all held keys.

## Test plan
- Reset with `row` swept 0x00–0xFF → `col`=5'b11111, `nmi`=0, `boot`=0.
- Frame 0x1C (A make), `row`=0xFD → `col`=5'b11110; `row`=0xFE → 5'b11111. Then F0 1C → `row`=0xFD gives 5'b11111.
- E0 6B (left arrow) → `row`=0xFE gives `col`=5'b11110 and `row`=0xF7 gives 5'b01111; `row`=0xF6 gives 5'b01110. Then E0 F0 6B → all 5'b11111.
- 12 (LShift) make, 66 (Backspace) make, F0 66 → `row`=0xFE gives 5'b11110 and `row`=0xEF gives 5'b11111.
- Frame 0x1C with wrong parity → `col` stays 5'b11111. Then frame 0x03 (F5) → `nmi`=1; F0 03 → `nmi`=0.
- 5 bits of a frame, then idle for `TOUT`+10 clocks, then a full valid 0x1C frame → `row`=0xFD gives 5'b11110.

Source files
------------

// File: rtl/keyboard_if.sv
// Pin-level bundle between the TS2068 core and the PS/2 keyboard front end:
// PS/2 pins, CPU half-row select and the decoded key columns and function levels.
interface keyboard_if;
   logic       ps2Ck;
   logic       ps2Dt;
   logic [7:0] row;
   logic [4:0] col;
   logic       nmi;
   logic       boot;

   modport master (output ps2Ck, ps2Dt, row, input col, nmi, boot);
   modport slave  (input ps2Ck, ps2Dt, row, output col, nmi, boot);
endinterface

// File: rtl/keyboard.sv
// PS/2 scan-code set 2 receiver and decoder feeding a 40-key Spectrum matrix,
// with port-FE column readback and F5/F11 levels for NMI and reset request.
module keyboard #(
   parameter int TOUT = 56000
) (
   input logic       clock,
   input logic       reset,
   keyboard_if.slave kbd
);
   localparam int IW = $clog2(TOUT + 1);

   logic [2:0]    ckS_q;
   logic [1:0]    dtS_q;
   logic [9:0]    frame_q, frame_d;
   logic [3:0]    bitCnt_q, bitCnt_d;
   logic [IW-1:0] idle_q, idle_d;
   logic          byteStb_q, byteStb_d;
   logic [7:0]    byte_q, byte_d;
   logic          brk_q, brk_d, ext_q, ext_d;
   logic [39:0]   direct_q, direct_d;
   logic [7:0]    spec_q, spec_d;
   logic          fall, frameOk;
   logic [10:0]   frameNext;
   logic [6:0]    dirHit;
   logic [3:0]    spcHit;
   logic [39:0]   keys;
   logic [4:0]    acc;

   // ckS_q[2] is the previous synchronised clock level used for edge detection
   assign fall      = ckS_q[2] & ~ckS_q[1];
   assign frameNext = {dtS_q[1], frame_q};
   assign frameOk   = ~frameNext[0] & frameNext[10] & (^frameNext[9:1]);

   always_comb begin
      frame_d   = frame_q;
      bitCnt_d  = bitCnt_q;
      idle_d    = idle_q;
      byteStb_d = 1'b0;
      byte_d    = byte_q;
      if (fall) begin
         idle_d  = '0;
         frame_d = frameNext[10:1];
         if (bitCnt_q == 4'd10) begin
            bitCnt_d = 4'd0;
            if (frameOk) begin
               byteStb_d = 1'b1;
               byte_d    = frameNext[8:1];
            end
         end else begin
            bitCnt_d = bitCnt_q + 4'd1;
         end
      end else begin
         if (idle_q != IW'(TOUT)) idle_d = idle_q + IW'(1);
         if (bitCnt_q != 4'd0 && idle_q == IW'(TOUT)) bitCnt_d = 4'd0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ckS_q     <= '1;
         dtS_q     <= '1;
         frame_q   <= '0;
         bitCnt_q  <= '0;
         idle_q    <= '0;
         byteStb_q <= 1'b0;
         byte_q    <= '0;
      end else begin
         ckS_q     <= {ckS_q[1:0], kbd.ps2Ck};
         dtS_q     <= {dtS_q[0], kbd.ps2Dt};
         frame_q   <= frame_d;
         bitCnt_q  <= bitCnt_d;
         idle_q    <= idle_d;
         byteStb_q <= byteStb_d;
         byte_q    <= byte_d;
      end
   end

   // Returns {hit, matrix index r*5+c} for keys that land on a single matrix position
   function automatic logic [6:0] directLookup(input logic [7:0] c);
      logic [6:0] r;
      r = '0;
      case (c)
         8'h12: r = {1'b1, 6'd0};   8'h1A: r = {1'b1, 6'd1};
         8'h22: r = {1'b1, 6'd2};   8'h21: r = {1'b1, 6'd3};
         8'h2A: r = {1'b1, 6'd4};   8'h1C: r = {1'b1, 6'd5};
         8'h1B: r = {1'b1, 6'd6};   8'h23: r = {1'b1, 6'd7};
         8'h2B: r = {1'b1, 6'd8};   8'h34: r = {1'b1, 6'd9};
         8'h15: r = {1'b1, 6'd10};  8'h1D: r = {1'b1, 6'd11};
         8'h24: r = {1'b1, 6'd12};  8'h2D: r = {1'b1, 6'd13};
         8'h2C: r = {1'b1, 6'd14};  8'h16: r = {1'b1, 6'd15};
         8'h1E: r = {1'b1, 6'd16};  8'h26: r = {1'b1, 6'd17};
         8'h25: r = {1'b1, 6'd18};  8'h2E: r = {1'b1, 6'd19};
         8'h45: r = {1'b1, 6'd20};  8'h46: r = {1'b1, 6'd21};
         8'h3E: r = {1'b1, 6'd22};  8'h3D: r = {1'b1, 6'd23};
         8'h36: r = {1'b1, 6'd24};  8'h4D: r = {1'b1, 6'd25};
         8'h44: r = {1'b1, 6'd26};  8'h43: r = {1'b1, 6'd27};
         8'h3C: r = {1'b1, 6'd28};  8'h35: r = {1'b1, 6'd29};
         8'h5A: r = {1'b1, 6'd30};  8'h4B: r = {1'b1, 6'd31};
         8'h42: r = {1'b1, 6'd32};  8'h3B: r = {1'b1, 6'd33};
         8'h33: r = {1'b1, 6'd34};  8'h29: r = {1'b1, 6'd35};
         8'h59: r = {1'b1, 6'd36};  8'h3A: r = {1'b1, 6'd37};
         8'h31: r = {1'b1, 6'd38};  8'h32: r = {1'b1, 6'd39};
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] specialLookup(input logic [8:0] c);
      logic [3:0] r;
      r = '0;
      case (c)
         9'h014: r = 4'h8;  9'h066: r = 4'h9;
         9'h16B: r = 4'hA;  9'h172: r = 4'hB;
         9'h175: r = 4'hC;  9'h174: r = 4'hD;
         9'h003: r = 4'hE;  9'h078: r = 4'hF;
         default: r = '0;
      endcase
      return r;
   endfunction

   assign dirHit = directLookup(byte_q);
   assign spcHit = specialLookup({ext_q, byte_q});

   always_comb begin
      brk_d    = brk_q;
      ext_d    = ext_q;
      direct_d = direct_q;
      spec_d   = spec_q;
      if (byteStb_q) begin
         if (byte_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            if (!ext_q && dirHit[6]) direct_d[dirHit[5:0]] = ~brk_q;
            if (spcHit[3]) spec_d[spcHit[2:0]] = ~brk_q;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         brk_q    <= 1'b0;
         ext_q    <= 1'b0;
         direct_q <= '0;
         spec_q   <= '0;
      end else begin
         brk_q    <= brk_d;
         ext_q    <= ext_d;
         direct_q <= direct_d;
         spec_q   <= spec_d;
      end
   end

   // Composite host keys (Ctrl, Backspace, arrows) are OR-ed onto their matrix keys
   always_comb begin
      keys     = direct_q;
      keys[0]  = direct_q[0] | (|spec_q[5:1]);
      keys[20] = direct_q[20] | spec_q[1];
      keys[19] = direct_q[19] | spec_q[2];
      keys[24] = direct_q[24] | spec_q[3];
      keys[23] = direct_q[23] | spec_q[4];
      keys[22] = direct_q[22] | spec_q[5];
      keys[36] = direct_q[36] | spec_q[0];
   end

   always_comb begin
      acc = '0;
      for (int r = 0; r < 8; r++) begin
         if (!kbd.row[r]) acc = acc | keys[r*5 +: 5];
      end
      kbd.col = ~acc;
   end

   assign kbd.nmi  = spec_q[6];
   assign kbd.boot = spec_q[7];
endmodule
